// File: rtl/pm_pkg.sv
// pm_pkg: shared encodings, FSM state type and instruction ROM contents
// for the point-multiplication instruction sequencer.
// Instruction word: {op[1:0], ins[1:0], src_a[3:0], src_b[3:0], dst[3:0]}.
package pm_pkg;

    localparam int unsigned PKG_ISSUE_W = 3;
    localparam int unsigned PKG_INS_W   = 16;
    localparam int unsigned ROW_W       = PKG_ISSUE_W * PKG_INS_W;
    localparam int unsigned RND_W       = 4;

    typedef enum logic [1:0] {
        OP_MUL = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2,
        OP_NUL = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        INS_CAL      = 2'd0,
        INS_UPDT_REG = 2'd1,
        INS_FIN      = 2'd2,
        INS_NULL     = 2'd3
    } ins_t;

    typedef enum logic [3:0] {
        OP_X0   = 4'd0,
        OP_Y0   = 4'd1,
        OP_Z0   = 4'd2,
        OP_X1   = 4'd3,
        OP_Y1   = 4'd4,
        OP_Z1   = 4'd5,
        OP_X2   = 4'd6,
        OP_Y2   = 4'd7,
        OP_Z2   = 4'd8,
        OP_T0   = 4'd9,
        OP_T1   = 4'd10,
        OP_T2   = 4'd11,
        OP_NULL = 4'd15
    } reg_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SCAN,
        S_PD_ISS,
        S_PD_WAIT,
        S_PA_ISS,
        S_PA_WAIT,
        S_FIN,
        S_NEXT,
        S_DONE
    } pm_state_t;

    localparam logic [PKG_INS_W-1:0] INS_NULL_WORD = {OP_NUL, INS_NULL, OP_NULL, OP_NULL, OP_NULL};
    localparam logic [PKG_INS_W-1:0] INS_FIN_WORD  = {OP_NUL, INS_FIN, 4'h0, 4'h0, 4'h0};
    localparam logic [ROW_W-1:0]     ROW_NULL      = {PKG_ISSUE_W{INS_NULL_WORD}};
    localparam logic [ROW_W-1:0]     ROW_FIN       = {INS_FIN_WORD, {(PKG_ISSUE_W-1){INS_NULL_WORD}}};

    function automatic logic [PKG_INS_W-1:0] cal(op_t op, reg_t a, reg_t b, reg_t d);
        return {op, INS_CAL, a, b, d};
    endfunction

    function automatic logic [PKG_INS_W-1:0] updt(reg_t a, reg_t b, reg_t d);
        return {OP_NUL, INS_UPDT_REG, a, b, d};
    endfunction

    // Point-double rounds; round 10 also precomputes Z^2 for the following add.
    function automatic logic [ROW_W-1:0] pd_row(input logic [RND_W-1:0] rnd);
        case (rnd)
            4'd0:    return {cal(OP_MUL, OP_Z0, OP_Z0, OP_T2), INS_NULL_WORD, INS_NULL_WORD};
            4'd1:    return {cal(OP_MUL, OP_X0, OP_X0, OP_T0), cal(OP_MUL, OP_Y0, OP_Y0, OP_T1), INS_NULL_WORD};
            4'd2:    return {cal(OP_ADD, OP_T0, OP_T0, OP_X2), cal(OP_MUL, OP_T1, OP_T1, OP_Y2), INS_NULL_WORD};
            4'd3:    return {cal(OP_ADD, OP_X2, OP_T0, OP_T0), cal(OP_MUL, OP_X0, OP_T1, OP_T1), INS_NULL_WORD};
            4'd4:    return {cal(OP_ADD, OP_T1, OP_T1, OP_T1), cal(OP_MUL, OP_Y0, OP_Z0, OP_Z2), INS_NULL_WORD};
            4'd5:    return {cal(OP_ADD, OP_T1, OP_T1, OP_T1), cal(OP_ADD, OP_Z2, OP_Z2, OP_Z2), INS_NULL_WORD};
            4'd6:    return {cal(OP_MUL, OP_T0, OP_T0, OP_X2), cal(OP_ADD, OP_Y2, OP_Y2, OP_Y2), INS_NULL_WORD};
            4'd7:    return {cal(OP_SUB, OP_X2, OP_T1, OP_X2), cal(OP_ADD, OP_Y2, OP_Y2, OP_Y2), INS_NULL_WORD};
            4'd8:    return {cal(OP_SUB, OP_X2, OP_T1, OP_X2), cal(OP_ADD, OP_Y2, OP_Y2, OP_Y2), INS_NULL_WORD};
            4'd9:    return {cal(OP_SUB, OP_T1, OP_X2, OP_T1), INS_NULL_WORD, INS_NULL_WORD};
            4'd10:   return {cal(OP_MUL, OP_T0, OP_T1, OP_T1), cal(OP_MUL, OP_Z2, OP_Z2, OP_T2), INS_NULL_WORD};
            4'd11:   return {cal(OP_SUB, OP_T1, OP_Y2, OP_Y2), updt(OP_X2, OP_Y2, OP_Z2), INS_NULL_WORD};
            default: return ROW_NULL;
        endcase
    endfunction

    // Point-add rounds; round 0 is never issued, PD round 10 covers it.
    function automatic logic [ROW_W-1:0] pa_row(input logic [RND_W-1:0] rnd);
        case (rnd)
            4'd0:    return {cal(OP_MUL, OP_Z1, OP_Z1, OP_T2), INS_NULL_WORD, INS_NULL_WORD};
            4'd1:    return {cal(OP_MUL, OP_T2, OP_T0, OP_T1), cal(OP_MUL, OP_X1, OP_T2, OP_Z2), INS_NULL_WORD};
            4'd2:    return {cal(OP_MUL, OP_Y1, OP_T1, OP_T1), cal(OP_MUL, OP_Z0, OP_Z0, OP_T0), INS_NULL_WORD};
            4'd3:    return {cal(OP_SUB, OP_Z2, OP_X0, OP_Z2), cal(OP_SUB, OP_T1, OP_Y0, OP_T1), INS_NULL_WORD};
            4'd4:    return {cal(OP_MUL, OP_Z2, OP_Z2, OP_T0), cal(OP_MUL, OP_Z0, OP_Z2, OP_Z2), INS_NULL_WORD};
            4'd5:    return {cal(OP_MUL, OP_T0, OP_Z2, OP_T2), cal(OP_MUL, OP_X0, OP_T0, OP_T0), INS_NULL_WORD};
            4'd6:    return {cal(OP_MUL, OP_T1, OP_T1, OP_X2), cal(OP_ADD, OP_T0, OP_T0, OP_Y2), INS_NULL_WORD};
            4'd7:    return {cal(OP_SUB, OP_X2, OP_T2, OP_X2), cal(OP_MUL, OP_Y0, OP_T2, OP_T2), INS_NULL_WORD};
            4'd8:    return {cal(OP_SUB, OP_X2, OP_Y2, OP_X2), INS_NULL_WORD, INS_NULL_WORD};
            4'd9:    return {cal(OP_SUB, OP_T0, OP_X2, OP_T0), updt(OP_X2, OP_Y2, OP_Z2), INS_NULL_WORD};
            default: return ROW_NULL;
        endcase
    endfunction

endpackage

// File: rtl/pm_ins_rom.sv
// pm_ins_rom: combinational instruction-row lookup, PD or PA table by mode.
module pm_ins_rom
    import pm_pkg::*;
(
    input  logic             mode_pa,
    input  logic [RND_W-1:0] rnd,
    output logic [ROW_W-1:0] row
);

    // Select the point-add or point-double row for the current round.
    always_comb begin
        row = ROW_NULL;
        if (mode_pa) row = pa_row(rnd);
        else         row = pd_row(rnd);
    end

endmodule

// File: rtl/pm_ins_seq.sv
// pm_ins_seq: scalar point-multiplication instruction sequencer.
// Scans k MSB-first and issues PD / PA instruction rounds to point_cal_top,
// one round per ins_vld_o strobe, handshaken by intr_cal_done_i.
// Optional: define PM_FAST_SCAN_EN for a one-cycle priority-encoder scan of
// the leading one; the issued instruction stream is the same either way.
module pm_ins_seq
    import pm_pkg::*;
#(
    parameter int unsigned K_W     = 256,
    parameter int unsigned ISSUE_W = PKG_ISSUE_W,
    parameter int unsigned INS_W   = PKG_INS_W,
    parameter int unsigned PD_RND  = 12,
    parameter int unsigned PA_RND  = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic [K_W-1:0]           k_i,
    input  logic                     abort_i,
    input  logic                     intr_cal_done_i,
    output logic [ISSUE_W*INS_W-1:0] ins_o,
    output logic                     ins_vld_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     zero_k_o
);

    localparam int unsigned CNT_W = $clog2(K_W + 1);

    pm_state_t        state;
    logic [K_W-1:0]   k_reg;
    logic [CNT_W-1:0] cnt;
    logic [RND_W-1:0] rnd;
    logic [RND_W-1:0] rnd_inc;
    logic             first;
    logic             mode_pa;
    logic [ROW_W-1:0] rom_row;
    logic             last_pd;
    logic             last_pa;

    pm_ins_rom u_rom (
        .mode_pa (mode_pa),
        .rnd     (rnd),
        .row     (rom_row)
    );

    // Round bookkeeping shared by both wait states.
    always_comb begin
        rnd_inc = rnd + RND_W'(1);
        last_pd = (rnd_inc == RND_W'(PD_RND));
        last_pa = (rnd_inc == RND_W'(PA_RND));
    end

`ifdef PM_FAST_SCAN_EN
    logic             lead_found;
    logic [CNT_W-1:0] lz;
    logic [CNT_W-1:0] shamt;

    // Leading-zero count of k_reg; shift amount steps past the leading one.
    always_comb begin
        lead_found = 1'b0;
        lz         = '0;
        for (int unsigned i = 0; i < K_W; i++) begin
            if (!lead_found && k_reg[K_W-1-i]) begin
                lead_found = 1'b1;
                lz         = CNT_W'(i);
            end
        end
        shamt = lz + CNT_W'(1);
    end
`endif

    // Sequencer FSM with registered issue, busy, done and zero-k outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            k_reg     <= '0;
            cnt       <= '0;
            rnd       <= '0;
            first     <= 1'b0;
            mode_pa   <= 1'b0;
            ins_o     <= ROW_NULL;
            ins_vld_o <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
            zero_k_o  <= 1'b0;
        end else begin
            ins_vld_o <= 1'b0;
            done_o    <= 1'b0;
            if (abort_i) begin
                state  <= S_IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            k_reg    <= k_i;
                            cnt      <= CNT_W'(K_W);
                            busy_o   <= 1'b1;
                            zero_k_o <= 1'b0;
                            state    <= S_SCAN;
                        end
                    end
                    S_SCAN: begin
`ifdef PM_FAST_SCAN_EN
                        if (lead_found) begin
                            k_reg <= k_reg << shamt;
                            cnt   <= CNT_W'(K_W - 1) - lz;
                            first <= 1'b1;
                            state <= S_NEXT;
                        end else begin
                            cnt      <= '0;
                            zero_k_o <= 1'b1;
                            state    <= S_DONE;
                        end
`else
                        k_reg <= k_reg << 1;
                        cnt   <= cnt - CNT_W'(1);
                        if (k_reg[K_W-1]) begin
                            first <= 1'b1;
                            state <= S_NEXT;
                        end else if (cnt == CNT_W'(1)) begin
                            zero_k_o <= 1'b1;
                            state    <= S_DONE;
                        end
`endif
                    end
                    S_NEXT: begin
                        if (cnt == '0) begin
                            state <= S_DONE;
                        end else begin
                            mode_pa <= 1'b0;
                            rnd     <= first ? RND_W'(0) : RND_W'(1);
                            state   <= S_PD_ISS;
                        end
                    end
                    S_PD_ISS: begin
                        ins_o     <= rom_row;
                        ins_vld_o <= 1'b1;
                        state     <= S_PD_WAIT;
                    end
                    S_PD_WAIT: begin
                        if (intr_cal_done_i) begin
                            rnd   <= rnd_inc;
                            state <= last_pd ? S_FIN : S_PD_ISS;
                        end
                    end
                    S_PA_ISS: begin
                        ins_o     <= rom_row;
                        ins_vld_o <= 1'b1;
                        state     <= S_PA_WAIT;
                    end
                    S_PA_WAIT: begin
                        if (intr_cal_done_i) begin
                            rnd   <= rnd_inc;
                            state <= last_pa ? S_FIN : S_PA_ISS;
                        end
                    end
                    S_FIN: begin
                        ins_o     <= ROW_FIN;
                        ins_vld_o <= 1'b1;
                        // A set bit is consumed only after its PA, so the
                        // shift is deferred when a PD is followed by a PA.
                        if (!mode_pa && k_reg[K_W-1]) begin
                            mode_pa <= 1'b1;
                            rnd     <= RND_W'(1);
                            state   <= S_PA_ISS;
                        end else begin
                            k_reg <= k_reg << 1;
                            cnt   <= cnt - CNT_W'(1);
                            first <= 1'b0;
                            state <= S_NEXT;
                        end
                    end
                    S_DONE: begin
                        done_o <= 1'b1;
                        busy_o <= 1'b0;
                        state  <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pm_ins_seq.sv
// tb_pm_ins_seq: scoreboard bench for pm_ins_seq. Directed scalars push
// expected instruction rows into a queue; a monitor pops on every strobe.
module tb_pm_ins_seq;

    localparam int unsigned K_W = 256;

    // Hand-encoded rows: {op,ins,a,b,dst} per 16-bit slot, slot 0 in MSBs.
    localparam logic [47:0] ROW_NULL_E = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] ROW_FIN_E  = 48'hE000_FFFF_FFFF;
    localparam logic [47:0] PD_ROW0_E  = 48'h022B_FFFF_FFFF;
    localparam logic [47:0] PA_ROW1_E  = 48'h0B9A_03B8_FFFF;
    localparam logic [255:0] K_ABORT   =
        256'h59276E27_3A1F0C55_9D42E7B8_06C3F1A4_72D95E08_B1C64F3A_E0957D12_8A4FBC21;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start_i = 1'b0;
    logic [K_W-1:0] k_i = '0;
    logic           abort_i = 1'b0;
    logic           intr_cal_done_i;
    logic [47:0]    ins_o;
    logic           ins_vld_o;
    logic           busy_o;
    logic           done_o;
    logic           zero_k_o;

    logic resp_pulse = 1'b0;
    logic spur_pulse = 1'b0;
    assign intr_cal_done_i = resp_pulse | spur_pulse;

    typedef struct packed {
        logic        exact;
        logic [47:0] row;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   strobes = 0;
    int   done_cnt = 0;
    int   resp_seen = 0;
    int   resp_stop = 0;
    int   push_n;
    int   push_lim;

    pm_ins_seq dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (start_i),
        .k_i             (k_i),
        .abort_i         (abort_i),
        .intr_cal_done_i (intr_cal_done_i),
        .ins_o           (ins_o),
        .ins_vld_o       (ins_vld_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .zero_k_o        (zero_k_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic exact, input logic [47:0] row);
        exp_t e;
        if (push_n < push_lim) begin
            e.exact = exact;
            e.row   = row;
            q.push_back(e);
        end
        push_n++;
    endtask

    // Expected stream: after the leading one, every remaining bit is a PD
    // (12 rounds first time, 11 after) + FIN, and a set bit adds 9 PA + FIN.
    task automatic push_scalar(input logic [255:0] k, input int lim);
        int  msb;
        bit  first;
        msb      = -1;
        push_n   = 0;
        push_lim = lim;
        for (int i = K_W - 1; i >= 0; i--) begin
            if (k[i] && msb < 0) msb = i;
        end
        first = 1'b1;
        for (int b = msb - 1; b >= 0; b--) begin
            for (int r = (first ? 0 : 1); r < 12; r++) begin
                if (r == 0) push(1'b1, PD_ROW0_E);
                else        push(1'b0, '0);
            end
            push(1'b1, ROW_FIN_E);
            if (k[b]) begin
                push(1'b1, PA_ROW1_E);
                for (int r = 2; r < 10; r++) push(1'b0, '0);
                push(1'b1, ROW_FIN_E);
            end
            first = 1'b0;
        end
    endtask

    // Monitor: pop and compare on every issue strobe; count done pulses.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ins_vld_o) begin
                strobes++;
                if (q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_strobe: got row %h with no entry expected", ins_o);
                end else begin
                    e = q.pop_front();
                    if (e.exact) chk("row_exact", {16'h0, ins_o}, {16'h0, e.row});
                    else chk("row_cal_slot0",
                             {63'h0, (ins_o[47:32] != 16'hFFFF) && (ins_o[47:32] != 16'hE000)},
                             64'h1);
                end
            end
            if (done_o) done_cnt++;
        end
    end

    // Responder: answer each non-FIN round 5 cycles after its strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (ins_vld_o && ins_o[47:32] != 16'hE000) begin
                resp_seen++;
                if (resp_seen != resp_stop) begin
                    repeat (4) @(negedge clk);
                    resp_pulse = 1'b1;
                    @(negedge clk);
                    resp_pulse = 1'b0;
                end
            end
        end
    end

    task automatic do_start(input logic [255:0] k);
        @(negedge clk);
        k_i     = k;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input string name, input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
        chk(name, 64'(done_cnt), 64'(target));
    endtask

    task automatic run_k6(input string tag);
        int s0, d0;
        s0 = strobes;
        d0 = done_cnt;
        push_scalar(256'd6, 1000);
        do_start(256'd6);
        chk({tag, "_busy_after_start"}, {63'h0, busy_o}, 64'h1);
        repeat (100) @(negedge clk);
        k_i     = 256'd2;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done({tag, "_done"}, d0 + 1, 3000);
        repeat (5) @(negedge clk);
        chk({tag, "_done_once"}, 64'(done_cnt), 64'(d0 + 1));
        chk({tag, "_busy_low"}, {63'h0, busy_o}, 64'h0);
        chk({tag, "_zero_k"}, {63'h0, zero_k_o}, 64'h0);
        chk({tag, "_strobes"}, 64'(strobes - s0), 64'd35);
        chk({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
    endtask

    initial begin
        int s0, d0;
        repeat (3) @(negedge clk);
        chk("rst_ins_o", {16'h0, ins_o}, {16'h0, ROW_NULL_E});
        chk("rst_vld", {63'h0, ins_vld_o}, 64'h0);
        chk("rst_busy", {63'h0, busy_o}, 64'h0);
        chk("rst_done", {63'h0, done_o}, 64'h0);
        chk("rst_zero_k", {63'h0, zero_k_o}, 64'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // k=6 with a start pulse (k=2) while busy that must be ignored.
        run_k6("k6a");

        // k=1: leading one only, nothing to issue.
        s0 = strobes;
        d0 = done_cnt;
        do_start(256'd1);
        wait_done("k1_done", d0 + 1, 1000);
        repeat (3) @(negedge clk);
        chk("k1_strobes", 64'(strobes - s0), 64'd0);
        chk("k1_zero_k", {63'h0, zero_k_o}, 64'h0);

        // k=0: zero flag, no issue.
        s0 = strobes;
        d0 = done_cnt;
        do_start(256'd0);
        wait_done("k0_done", d0 + 1, 1000);
        repeat (3) @(negedge clk);
        chk("k0_strobes", 64'(strobes - s0), 64'd0);
        chk("k0_zero_k", {63'h0, zero_k_o}, 64'h1);

        // k=2 with a spurious round-done pulse during SCAN.
        s0 = strobes;
        d0 = done_cnt;
        push_scalar(256'd2, 1000);
        do_start(256'd2);
        spur_pulse = 1'b1;
        @(negedge clk);
        spur_pulse = 1'b0;
        chk("k2_zero_k_cleared", {63'h0, zero_k_o}, 64'h0);
        wait_done("k2_done", d0 + 1, 2000);
        repeat (3) @(negedge clk);
        chk("k2_strobes", 64'(strobes - s0), 64'd13);
        chk("k2_queue_empty", 64'(q.size()), 64'd0);

        // Abort in PA_WAIT: 12 PD + FIN, 11 PD + FIN, first PA round, then abort.
        s0 = strobes;
        d0 = done_cnt;
        resp_seen = 0;
        resp_stop = 24;
        push_scalar(K_ABORT, 26);
        do_start(K_ABORT);
        for (int i = 0; i < 3000 && strobes < s0 + 26; i++) @(negedge clk);
        chk("abort_reach_pa", 64'(strobes - s0), 64'd26);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("abort_busy_low", {63'h0, busy_o}, 64'h0);
        repeat (50) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt), 64'(d0));
        chk("abort_strobes", 64'(strobes - s0), 64'd26);
        chk("abort_queue_empty", 64'(q.size()), 64'd0);
        resp_stop = 0;

        // start and abort together in IDLE: start is dropped.
        d0 = done_cnt;
        @(negedge clk);
        k_i     = 256'd6;
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("start_abort_busy", {63'h0, busy_o}, 64'h0);
        repeat (300) @(negedge clk);
        chk("start_abort_no_done", 64'(done_cnt), 64'(d0));

        // Full k=6 stream again after the abort.
        run_k6("k6b");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
